// File: rtl/id_stage_sb.sv
// Decode stage with valid/ready handshakes, an internal register file and a
// per-register scoreboard. Optional macro WB_BYPASS_EN forwards write-back data into the decode.
module id_stage_sb #(
    parameter int XLEN = 32,
    parameter int AW   = 4,
    parameter int PCW  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [31:0]          inst_i,
    input  logic [PCW-1:0]       pc_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [5:0]           out_ctrl_o,
    output logic                 out_und_o,
    output logic                 out_rsv_o,
    output logic                 out_immf_o,
    output logic [XLEN-1:0]      out_imm_o,
    output logic [XLEN-1:0]      out_rd_value_o,
    output logic [XLEN-1:0]      out_rs_value_o,
    output logic [AW-1:0]        out_rd_addr_o,
    output logic [6:0]           out_opcode_o,
    output logic [PCW-1:0]       out_pc_o,
    input  logic                 wb_i,
    input  logic [AW-1:0]        wb_r_i,
    input  logic [XLEN-1:0]      wb_data_i,
    output logic [(1<<AW)-1:0]   sb_busy_o,
    output logic [15:0]          stall_cnt_o
);

    localparam int NREG = 1 << AW;

    function automatic logic [XLEN-1:0] ext_imm(input logic [15:0] imm, input logic zext);
        logic signed [15:0] simm;
        simm = imm;
        if (zext)
            return {{(XLEN-16){1'b0}}, imm};
        return {{(XLEN-16){simm[15]}}, simm};
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [6:0]      opcode;
    logic [AW-1:0]   rd_a;
    logic [AW-1:0]   rs_a;
    logic [5:0]      dec_ctrl;
    logic            dec_und;
    logic            dec_rsv;
    logic            dec_zext;
    logic            dec_jump;
    logic            dec_reader;
    logic            byp_rd;
    logic            byp_rs;
    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] rs_val;

    logic            out_valid_q, out_valid_d;
    logic [5:0]      ctrl_q, ctrl_d;
    logic            und_q, und_d;
    logic            rsv_q, rsv_d;
    logic            immf_q, immf_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [XLEN-1:0] rd_value_q, rd_value_d;
    logic [XLEN-1:0] rs_value_q, rs_value_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [PCW-1:0]  pc_q, pc_d;
    logic [NREG-1:0] sb_q, sb_d;
    logic [15:0]     stall_q, stall_d;
    logic [XLEN-1:0] rf_q [NREG];
    logic [XLEN-1:0] rf_d [NREG];

    assign opcode = inst_i[31:25];
    assign rd_a   = inst_i[20 +: AW];
    assign rs_a   = inst_i[16 +: AW];

    always_comb begin
        dec_ctrl = 6'b000000;
        dec_und  = 1'b0;
        dec_rsv  = 1'b0;
        dec_zext = 1'b0;
        dec_jump = 1'b0;
        case (opcode)
            7'h00, 7'h01, 7'h02, 7'h03, 7'h05, 7'h06, 7'h07: begin
                dec_ctrl = 6'b100000;
                dec_rsv  = 1'b1;
            end
            7'h04: dec_ctrl = 6'b100000;
            7'h08, 7'h09, 7'h0A, 7'h0C, 7'h0D: begin
                dec_ctrl = 6'b001000;
                dec_rsv  = 1'b1;
                dec_zext = 1'b1;
            end
            7'h10, 7'h11, 7'h12, 7'h13: begin
                dec_ctrl = 6'b010000;
                dec_rsv  = 1'b1;
            end
            7'h16, 7'h17: dec_rsv = 1'b1;
            7'h18: begin
                dec_ctrl = 6'b000100;
                dec_rsv  = 1'b1;
            end
            7'h19:        dec_ctrl = 6'b000010;
            7'h1C, 7'h1D: dec_ctrl = 6'b000001;
            7'h1E, 7'h1F: dec_jump = 1'b1;
            default:      dec_und  = 1'b1;
        endcase
    end

    assign dec_reader = ~dec_und & ~dec_jump;

`ifdef WB_BYPASS_EN
    assign byp_rd = wb_i & (wb_r_i == rd_a);
    assign byp_rs = wb_i & (wb_r_i == rs_a);
`else
    assign byp_rd = 1'b0;
    assign byp_rs = 1'b0;
`endif

    // A write-back landing this cycle on a busy operand resolves the hazard only when forwarded.
    assign hazard = dec_reader & ((sb_q[rd_a] & ~byp_rd) | (sb_q[rs_a] & ~byp_rs));
    assign rd_val = byp_rd ? wb_data_i : rf_q[rd_a];
    assign rs_val = byp_rs ? wb_data_i : rf_q[rs_a];

    assign in_ready_o = (~out_valid_q | out_ready_i) & ~hazard & ~flush_i;
    assign accept     = in_valid_i & in_ready_o;

    always_comb begin
        out_valid_d = out_valid_q;
        ctrl_d      = ctrl_q;
        und_d       = und_q;
        rsv_d       = rsv_q;
        immf_d      = immf_q;
        imm_d       = imm_q;
        rd_value_d  = rd_value_q;
        rs_value_d  = rs_value_q;
        rd_addr_d   = rd_addr_q;
        opcode_d    = opcode_q;
        pc_d        = pc_q;
        if (accept) begin
            out_valid_d = 1'b1;
            ctrl_d      = dec_ctrl;
            und_d       = dec_und;
            rsv_d       = dec_rsv;
            immf_d      = inst_i[24];
            imm_d       = ext_imm(inst_i[15:0], dec_zext);
            rd_value_d  = rd_val;
            rs_value_d  = rs_val;
            rd_addr_d   = rd_a;
            opcode_d    = opcode;
            pc_d        = pc_i;
        end else if (flush_i || out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Clears first, then the new reservation, so a same-register set beats a clear.
    always_comb begin
        sb_d = sb_q;
        if (wb_i)
            sb_d[wb_r_i] = 1'b0;
        if (flush_i && out_valid_q && rsv_q)
            sb_d[rd_addr_q] = 1'b0;
        if (accept && dec_rsv)
            sb_d[rd_a] = 1'b1;
    end

    always_comb begin
        stall_d = stall_q;
        if (in_valid_i && hazard && !flush_i)
            stall_d = sat_inc(stall_q);
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_i)
            rf_d[wb_r_i] = wb_data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ctrl_q      <= '0;
            und_q       <= 1'b0;
            rsv_q       <= 1'b0;
            immf_q      <= 1'b0;
            imm_q       <= '0;
            rd_value_q  <= '0;
            rs_value_q  <= '0;
            rd_addr_q   <= '0;
            opcode_q    <= '0;
            pc_q        <= '0;
            sb_q        <= '0;
            stall_q     <= '0;
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ctrl_q      <= ctrl_d;
            und_q       <= und_d;
            rsv_q       <= rsv_d;
            immf_q      <= immf_d;
            imm_q       <= imm_d;
            rd_value_q  <= rd_value_d;
            rs_value_q  <= rs_value_d;
            rd_addr_q   <= rd_addr_d;
            opcode_q    <= opcode_d;
            pc_q        <= pc_d;
            sb_q        <= sb_d;
            stall_q     <= stall_d;
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= rf_d[i];
        end
    end

    assign out_valid_o    = out_valid_q;
    assign out_ctrl_o     = ctrl_q;
    assign out_und_o      = und_q;
    assign out_rsv_o      = rsv_q;
    assign out_immf_o     = immf_q;
    assign out_imm_o      = imm_q;
    assign out_rd_value_o = rd_value_q;
    assign out_rs_value_o = rs_value_q;
    assign out_rd_addr_o  = rd_addr_q;
    assign out_opcode_o   = opcode_q;
    assign out_pc_o       = pc_q;
    assign sb_busy_o      = sb_q;
    assign stall_cnt_o    = stall_q;

endmodule

// File: tb/tb_id_stage_sb.sv
// Directed bench for id_stage_sb: a scoreboard queue holds the packet expected
// in the output register, compared every cycle it is valid.
module tb_id_stage_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] inst_i;
    logic [15:0] pc_i;
    logic        flush_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [5:0]  out_ctrl_o;
    logic        out_und_o;
    logic        out_rsv_o;
    logic        out_immf_o;
    logic [31:0] out_imm_o;
    logic [31:0] out_rd_value_o;
    logic [31:0] out_rs_value_o;
    logic [3:0]  out_rd_addr_o;
    logic [6:0]  out_opcode_o;
    logic [15:0] out_pc_o;
    logic        wb_i;
    logic [3:0]  wb_r_i;
    logic [31:0] wb_data_i;
    logic [15:0] sb_busy_o;
    logic [15:0] stall_cnt_o;

    id_stage_sb #(.XLEN(32), .AW(4), .PCW(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .inst_i(inst_i), .pc_i(pc_i), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_ctrl_o(out_ctrl_o), .out_und_o(out_und_o), .out_rsv_o(out_rsv_o),
        .out_immf_o(out_immf_o), .out_imm_o(out_imm_o),
        .out_rd_value_o(out_rd_value_o), .out_rs_value_o(out_rs_value_o),
        .out_rd_addr_o(out_rd_addr_o), .out_opcode_o(out_opcode_o), .out_pc_o(out_pc_o),
        .wb_i(wb_i), .wb_r_i(wb_r_i), .wb_data_i(wb_data_i),
        .sb_busy_o(sb_busy_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  ctrl;
        logic        und;
        logic        rsv;
        logic        immf;
        logic [31:0] imm;
        logic [31:0] rdv;
        logic [31:0] rsv_v;
        logic [3:0]  rda;
        logic [6:0]  op;
        logic [15:0] pc;
    } pkt_t;

    pkt_t        exp_q[$];
    logic [31:0] model_rf [16];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic immf,
                                       input logic [3:0] rd, input logic [3:0] rs,
                                       input logic [15:0] imm);
        return {op, immf, rd, rs, imm};
    endfunction

    function automatic pkt_t model(input logic [31:0] inst, input logic [15:0] pc);
        pkt_t p;
        logic [6:0] op;
        logic [3:0] rd;
        logic [3:0] rs;
        logic       zx;
        op = inst[31:25];
        rd = inst[23:20];
        rs = inst[19:16];
        p.ctrl = 6'b000000; p.und = 1'b0; p.rsv = 1'b0; zx = 1'b0;
        if (op <= 7'h07) begin
            p.ctrl = 6'b100000; p.rsv = (op != 7'h04);
        end else if (op inside {7'h08, 7'h09, 7'h0A, 7'h0C, 7'h0D}) begin
            p.ctrl = 6'b001000; p.rsv = 1'b1; zx = 1'b1;
        end else if (op inside {[7'h10:7'h13]}) begin
            p.ctrl = 6'b010000; p.rsv = 1'b1;
        end else if (op inside {7'h16, 7'h17}) begin
            p.rsv = 1'b1;
        end else if (op == 7'h18) begin
            p.ctrl = 6'b000100; p.rsv = 1'b1;
        end else if (op == 7'h19) begin
            p.ctrl = 6'b000010;
        end else if (op inside {7'h1C, 7'h1D}) begin
            p.ctrl = 6'b000001;
        end else if (!(op inside {7'h1E, 7'h1F})) begin
            p.und = 1'b1;
        end
        p.immf  = inst[24];
        p.imm   = zx ? {16'h0000, inst[15:0]} : {{16{inst[15]}}, inst[15:0]};
        p.rdv   = model_rf[rd];
        p.rsv_v = model_rf[rs];
`ifdef WB_BYPASS_EN
        if (wb_i && wb_r_i == rd) p.rdv = wb_data_i;
        if (wb_i && wb_r_i == rs) p.rsv_v = wb_data_i;
`endif
        p.rda = rd;
        p.op  = op;
        p.pc  = pc;
        return p;
    endfunction

    task automatic drv(input logic v, input logic [31:0] inst, input logic [15:0] pc);
        in_valid_i = v;
        inst_i     = inst;
        pc_i       = pc;
    endtask

    task automatic setwb(input logic en, input logic [3:0] r, input logic [31:0] d);
        wb_i      = en;
        wb_r_i    = r;
        wb_data_i = d;
    endtask

    // One cycle: check handshake and held packet, update the scoreboard, then clock.
    task automatic tick(input logic exp_rdy);
        pkt_t e;
        logic acc;
        #1;
        chk("in_ready", 64'(in_ready_o), 64'(exp_rdy));
        chk("out_valid", 64'(out_valid_o), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk("ctrl", 64'(out_ctrl_o), 64'(e.ctrl));
            chk("und", 64'(out_und_o), 64'(e.und));
            chk("rsv", 64'(out_rsv_o), 64'(e.rsv));
            chk("immf", 64'(out_immf_o), 64'(e.immf));
            chk("imm", 64'(out_imm_o), 64'(e.imm));
            chk("rd_value", 64'(out_rd_value_o), 64'(e.rdv));
            chk("rs_value", 64'(out_rs_value_o), 64'(e.rsv_v));
            chk("rd_addr", 64'(out_rd_addr_o), 64'(e.rda));
            chk("opcode", 64'(out_opcode_o), 64'(e.op));
            chk("pc", 64'(out_pc_o), 64'(e.pc));
            if (out_ready_i || flush_i)
                void'(exp_q.pop_front());
        end
        acc = in_valid_i && exp_rdy;
        if (acc)
            exp_q.push_back(model(inst_i, pc_i));
        @(posedge clk);
        #1;
        if (wb_i)
            model_rf[wb_r_i] = wb_data_i;
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        out_ready_i = 1'b0;
        drv(1'b0, 32'h0, 16'h0);
        setwb(1'b0, 4'h0, 32'h0);
        for (int i = 0; i < 16; i++) model_rf[i] = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_sb", 64'(sb_busy_o), 64'd0);
        chk("rst_stall", 64'(stall_cnt_o), 64'd0);
        chk("rst_ctrl", 64'(out_ctrl_o), 64'd0);
        rst = 1'b0;

        // Preload r3=5, r4=7, then a basic inte instruction.
        setwb(1'b1, 4'd3, 32'd5); tick(1'b1);
        setwb(1'b1, 4'd4, 32'd7); tick(1'b1);
        setwb(1'b0, 4'd0, 32'd0);
        out_ready_i = 1'b1;
        drv(1'b1, mk(7'h00, 1'b0, 4'd3, 4'd4, 16'h0010), 16'h0100); tick(1'b1);
        chk("first_ctrl", 64'(out_ctrl_o), 64'b100000);
        chk("first_rdv", 64'(out_rd_value_o), 64'd5);
        chk("first_rsv", 64'(out_rs_value_o), 64'd7);
        chk("sb_after_inte", 64'(sb_busy_o), 64'h0008);
        drv(1'b0, 32'h0, 16'h0);
        setwb(1'b1, 4'd3, 32'd5); tick(1'b1);
        setwb(1'b0, 4'd0, 32'd0);
        chk("sb_cleared_wb", 64'(sb_busy_o), 64'h0000);

        // Load-use hazard on r2.
        drv(1'b1, mk(7'h18, 1'b0, 4'd2, 4'd0, 16'h0004), 16'h0104); tick(1'b1);
        chk("sb_ld", 64'(sb_busy_o), 64'h0004);
        drv(1'b1, mk(7'h01, 1'b0, 4'd2, 4'd1, 16'h0001), 16'h0108);
        tick(1'b0);
        tick(1'b0);
        chk("stall_two", 64'(stall_cnt_o), 64'd2);
        setwb(1'b1, 4'd2, 32'h1234);
`ifdef WB_BYPASS_EN
        tick(1'b1);
        setwb(1'b0, 4'd0, 32'd0);
        exp_stall = 16'd2;
`else
        tick(1'b0);
        setwb(1'b0, 4'd0, 32'd0);
        tick(1'b1);
        exp_stall = 16'd3;
`endif
        chk("dep_rdv", 64'(out_rd_value_o), 64'h1234);
        chk("sb_set_wins", 64'(sb_busy_o), 64'h0004);
        chk("stall_after_wb", 64'(stall_cnt_o), 64'(exp_stall));
        drv(1'b0, 32'h0, 16'h0);
        setwb(1'b1, 4'd2, 32'h1234); tick(1'b1);
        setwb(1'b0, 4'd0, 32'd0);
        chk("sb_clear_r2", 64'(sb_busy_o), 64'h0000);

        // Immediate extension: shift zero-extends, logic sign-extends.
        drv(1'b1, mk(7'h08, 1'b1, 4'd5, 4'd6, 16'h8001), 16'h0110); tick(1'b1);
        chk("imm_shift", 64'(out_imm_o), 64'h00008001);
        drv(1'b1, mk(7'h10, 1'b0, 4'd6, 4'd7, 16'h8001), 16'h0114); tick(1'b1);
        chk("imm_logic", 64'(out_imm_o), 64'hFFFF8001);
        drv(1'b0, 32'h0, 16'h0);
        setwb(1'b1, 4'd5, 32'h55); tick(1'b1);
        setwb(1'b1, 4'd6, 32'h66); tick(1'b1);
        setwb(1'b0, 4'd0, 32'd0);
        chk("sb_clear_56", 64'(sb_busy_o), 64'h0000);

        // Backpressure: packet holds for three cycles, then the waiting one loads.
        out_ready_i = 1'b0;
        drv(1'b1, mk(7'h11, 1'b0, 4'd7, 4'd8, 16'h0AAA), 16'h0200); tick(1'b1);
        drv(1'b1, mk(7'h02, 1'b0, 4'd9, 4'd10, 16'h0BBB), 16'h0204);
        tick(1'b0); tick(1'b0); tick(1'b0);
        chk("hold_pc", 64'(out_pc_o), 64'h0200);
        out_ready_i = 1'b1;
        tick(1'b1);
        chk("next_pc", 64'(out_pc_o), 64'h0204);
        drv(1'b0, 32'h0, 16'h0); tick(1'b1);
        chk("sb_79", 64'(sb_busy_o), 64'h0280);
        chk("stall_unchanged", 64'(stall_cnt_o), 64'(exp_stall));

        // Flush of a held load releases its reservation and blocks acceptance.
        out_ready_i = 1'b0;
        drv(1'b1, mk(7'h18, 1'b0, 4'd5, 4'd11, 16'h0005), 16'h0300); tick(1'b1);
        chk("sb_ld5", 64'(sb_busy_o), 64'h02A0);
        drv(1'b1, mk(7'h00, 1'b0, 4'd12, 4'd13, 16'h0000), 16'h0304);
        flush_i = 1'b1; tick(1'b0);
        flush_i = 1'b0;
        chk("flush_valid", 64'(out_valid_o), 64'd0);
        chk("flush_sb", 64'(sb_busy_o), 64'h0280);
        drv(1'b0, 32'h0, 16'h0);
        out_ready_i = 1'b1; tick(1'b1);

        // Undefined opcode passes through and reserves nothing.
        drv(1'b1, mk(7'h7F, 1'b1, 4'd14, 4'd15, 16'hFFFF), 16'h0400); tick(1'b1);
        chk("und_flag", 64'(out_und_o), 64'd1);
        chk("und_rsv", 64'(out_rsv_o), 64'd0);
        chk("und_sb", 64'(sb_busy_o), 64'h0280);
        drv(1'b0, 32'h0, 16'h0); tick(1'b1);

        // Asynchronous reset in the middle of a stall.
        drv(1'b1, mk(7'h18, 1'b0, 4'd13, 4'd0, 16'h0000), 16'h0500); tick(1'b1);
        chk("sb_ld13", 64'(sb_busy_o), 64'h2280);
        drv(1'b1, mk(7'h00, 1'b0, 4'd3, 4'd13, 16'h0000), 16'h0504); tick(1'b0);
        chk("stall_mid", 64'(stall_cnt_o), 64'(exp_stall + 16'd1));
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(out_valid_o), 64'd0);
        chk("arst_sb", 64'(sb_busy_o), 64'd0);
        chk("arst_stall", 64'(stall_cnt_o), 64'd0);
        chk("arst_ctrl", 64'(out_ctrl_o), 64'd0);
        chk("arst_pc", 64'(out_pc_o), 64'd0);
        chk("arst_rdv", 64'(out_rd_value_o), 64'd0);
        exp_q.delete();
        for (int i = 0; i < 16; i++) model_rf[i] = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1'b1);
        chk("post_rst_rdv", 64'(out_rd_value_o), 64'd0);
        drv(1'b0, 32'h0, 16'h0); tick(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
